regdump_reader: RTL and testbench
=================================

REGDUMP_READER -- requirements
Module: regdump_reader

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: number of registers walked, addresses 0..NUM_REGS-1.
REQ-002 SHALL have parameter DATA_W, default 32: register word width.
REQ-003 SHALL have parameter ADR_W, default 5: register address width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a dump; sampled in IDLE only.
REQ-007 abort  input  1  synchronous cancel of a dump in progress.
REQ-008 rf_read_adr  output  ADR_W  read address driven to the register file read port.
REQ-009 rf_read_data  input  DATA_W  register file read data for rf_read_adr.
REQ-010 out_data  output  DATA_W  streamed word.
REQ-011 out_adr  output  ADR_W  register index of out_data.
REQ-012 out_valid  output  1  out_data, out_adr and out_last are valid.
REQ-013 out_ready  input  1  downstream accepts the word.
REQ-014 out_last  output  1  marks the final word of the dump.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on normal completion.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, SEND, CSUM, DONE.
REQ-018 IDLE: start=1 -> FETCH, address counter = 0; start=0 -> stay in IDLE.
REQ-019 FETCH: last one cycle with rf_read_adr = counter; at its end, register rf_read_data into out_data, counter into out_adr, then go to SEND.
REQ-020 SEND: out_valid=1; out_data, out_adr and out_last stay stable until out_valid & out_ready.
REQ-021 On a SEND handshake with counter < NUM_REGS-1: counter increments and the FSM goes to FETCH.
REQ-022 On a SEND handshake with counter = NUM_REGS-1: go to CSUM if configured (REQ-031), otherwise to DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; counter does not wrap past NUM_REGS-1.
REQ-024 Throughput: at most one word per 2 cycles; with out_ready held at 1, a full dump takes 2*NUM_REGS+2 cycles from start to done.
REQ-025 start while busy SHALL be ignored and not queued.
REQ-026 abort=1 in any non-IDLE state -> IDLE next cycle: no done pulse, out_valid=0, an in-flight word is discarded; abort has priority over out_ready in the same cycle.
REQ-027 start and abort both high in IDLE: abort wins, stay in IDLE.
REQ-028 rf_read_adr = counter in all states; the counter holds its value in IDLE.
REQ-029 out_last=1 only on the final word of the dump.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, counter=0, rf_read_adr=0, out_data=0, out_adr=0, out_valid=0, out_last=0, busy=0, done=0; reset mid-dump discards the dump with no done pulse.

Configuration
REQ-031 Macro REGDUMP_CHECKSUM_EN defined: the FSM XOR-accumulates every handshaken word (accumulator cleared on start); CSUM sends the accumulator as one extra word with out_adr=0 and out_last=1, then DONE after its handshake; dump length NUM_REGS+1 words.
REQ-032 REGDUMP_CHECKSUM_EN undefined: no CSUM state and no accumulator; the word at NUM_REGS-1 carries out_last=1; dump length NUM_REGS words.

Verification
REQ-033 Register file loaded with reg[i]=i*0x11111111, out_ready=1, pulse start -> 32 words, adr 0..31, data matching, done 66 cycles after start, out_last only on adr 31.
REQ-034 out_ready low for 5 cycles while word adr 3 is in SEND -> out_valid, out_data=0x33333333 and out_adr=3 hold stable; adr 4 follows the handshake.
REQ-035 abort asserted in SEND at adr 10 -> IDLE next cycle, out_valid=0, busy=0, no done; a new start then restarts from adr 0.
REQ-036 start pulsed again at adr 7 -> no effect; exactly one done, 32 (or 33) words.
REQ-037 With REGDUMP_CHECKSUM_EN, all registers 0 except reg[5]=0xA5A5A5A5 and reg[6]=0x0000FFFF -> 33rd word 0xA5A55A5A, out_adr=0, out_last=1.
REQ-038 rst_n pulsed low at adr 20 -> all outputs 0 immediately, FSM in IDLE, no done.

Source files
------------

// File: rtl/regdump_reader_if.sv
// regdump_reader_if: register-file read port plus the outbound word stream.
// master = dump engine side, slave = register file / downstream consumer side.
interface regdump_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADR_W  = 5
);
    logic [ADR_W-1:0]  rf_read_adr;
    logic [DATA_W-1:0] rf_read_data;
    logic [DATA_W-1:0] out_data;
    logic [ADR_W-1:0]  out_adr;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output rf_read_adr,
        input  rf_read_data,
        output out_data,
        output out_adr,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  rf_read_adr,
        output rf_read_data,
        input  out_data,
        input  out_adr,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regdump_reader.sv
// regdump_reader: walks registers 0..NUM_REGS-1 and streams them out.
// Optional trailing XOR checksum word when REGDUMP_CHECKSUM_EN is defined.
module regdump_reader #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADR_W    = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    regdump_reader_if.master bus
);

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SEND, S_CSUM, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SEND, S_DONE
    } state_t;
`endif

    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADR_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic              last_q, last_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
`endif

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            adr_q   <= '0;
            last_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            adr_q   <= adr_d;
            last_q  <= last_d;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // Next-state logic; abort overrides everything, including a handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        adr_d   = adr_q;
        last_d  = last_q;
`ifdef REGDUMP_CHECKSUM_EN
        acc_d   = acc_q;
`endif
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FETCH;
                        cnt_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
                        acc_d   = '0;
`endif
                    end
                end
                S_FETCH: begin
                    data_d  = bus.rf_read_data;
                    adr_d   = cnt_q;
`ifdef REGDUMP_CHECKSUM_EN
                    last_d  = 1'b0;
`else
                    last_d  = (cnt_q == LAST_ADR);
`endif
                    state_d = S_SEND;
                end
                S_SEND: begin
                    if (bus.out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
                        acc_d = acc_q ^ data_q;
`endif
                        if (cnt_q == LAST_ADR) begin
`ifdef REGDUMP_CHECKSUM_EN
                            // Checksum word reuses the output registers.
                            state_d = S_CSUM;
                            data_d  = acc_q ^ data_q;
                            adr_d   = '0;
                            last_d  = 1'b1;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            cnt_d   = cnt_q + ADR_W'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (bus.out_ready) begin
                        state_d = S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    assign bus.out_valid = (state_q == S_SEND) || (state_q == S_CSUM);
`else
    assign bus.out_valid = (state_q == S_SEND);
`endif
    assign bus.rf_read_adr = cnt_q;
    assign bus.out_data    = data_q;
    assign bus.out_adr     = adr_q;
    assign bus.out_last    = last_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_regdump_reader.sv
// tb_regdump_reader: directed scenarios with a queue scoreboard of expected words.
// Build with +define+REGDUMP_CHECKSUM_EN to exercise the checksum variant.
module tb_regdump_reader;
    localparam int N  = 32;
    localparam int DW = 32;
    localparam int AW = 5;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic done;
    logic [DW-1:0] rf [N];

    exp_t sb [$];
    int checks = 0;
    int errors = 0;
    int words = 0;
    int dones = 0;

    always #5 clk = ~clk;

    regdump_reader_if #(.DATA_W(DW), .ADR_W(AW)) bus ();

    assign bus.rf_read_data = rf[bus.rf_read_adr];

    regdump_reader #(.NUM_REGS(N), .DATA_W(DW), .ADR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop and compare on every accepted word, count done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready && !abort) begin
                words++;
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("word_adr", 32'(bus.out_adr), 32'(e.adr));
                    check("word_data", bus.out_data, e.data);
                    check("word_last", 32'(bus.out_last), 32'(e.last));
                end
            end
            if (done) dones++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int first, input int n);
        exp_t e;
        for (int i = first; i < first + n; i++) begin
            e.adr  = AW'(i);
            e.data = rf[i];
            e.last = (CS == 0) && (i == N - 1);
            sb.push_back(e);
        end
    endtask

    task automatic push_all();
        exp_t e;
        logic [DW-1:0] x;
        push_range(0, N);
        if (CS != 0) begin
            x = '0;
            for (int i = 0; i < N; i++) x = x ^ rf[i];
            e.adr  = '0;
            e.data = x;
            e.last = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_word(input int a);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.out_valid && (bus.out_adr == AW'(a))) begin
                ok = 1;
                break;
            end
            tick();
        end
        check($sformatf("reach_adr%0d", a), 32'(ok), 32'd1);
    endtask

    // n counts rising edges since the cycle in which start was high.
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rfadr"}, 32'(bus.rf_read_adr), 32'd0);
        check({tag, "_data"}, bus.out_data, 32'd0);
        check({tag, "_adr"}, 32'(bus.out_adr), 32'd0);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_last"}, 32'(bus.out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int d0;
        int w0;
        for (int i = 0; i < N; i++) rf[i] = 32'(i) * 32'h1111_1111;
        bus.out_ready = 1'b1;

        // Reset state
        #2;
        check_idle_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        // Full dump, ready held high: done in cycle 2*N+2 counting start cycle
        d0 = dones;
        w0 = words;
        push_all();
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(n);
        check("latency", 32'(n), 32'(2 * N + 1 + CS));
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("dump1_dones", 32'(dones - d0), 32'd1);
        check("dump1_words", 32'(words - w0), 32'(N + CS));
        check("dump1_sb_empty", 32'(sb.size()), 32'd0);

        // Back-pressure on word 3 for 5 cycles
        d0 = dones;
        push_all();
        pulse_start();
        wait_word(3);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_data", bus.out_data, 32'h3333_3333);
            check("stall_adr", 32'(bus.out_adr), 32'd3);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_word(4);
        wait_done(n);
        tick();
        check("stall_dones", 32'(dones - d0), 32'd1);
        check("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Abort in SEND at adr 10, abort beats a ready handshake
        d0 = dones;
        push_range(0, 10);
        pulse_start();
        wait_word(10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (4) tick();
        check("abort_no_done", 32'(dones - d0), 32'd0);
        check("abort_sb_empty", 32'(sb.size()), 32'd0);

        // Restart after abort begins at register 0
        push_all();
        pulse_start();
        check("restart_rfadr", 32'(bus.rf_read_adr), 32'd0);
        wait_done(n);
        tick();
        check("restart_dones", 32'(dones - d0), 32'd1);
        check("restart_sb_empty", 32'(sb.size()), 32'd0);

        // start while busy is ignored and not queued
        d0 = dones;
        w0 = words;
        push_all();
        pulse_start();
        wait_word(7);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        repeat (6) tick();
        check("restart_ignored_busy", 32'(busy), 32'd0);
        check("busy_start_dones", 32'(dones - d0), 32'd1);
        check("busy_start_words", 32'(words - w0), 32'(N + CS));
        check("busy_start_sb_empty", 32'(sb.size()), 32'd0);

        // start and abort together in IDLE: stay idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a dump
        d0 = dones;
        push_range(0, 20);
        pulse_start();
        wait_word(20);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_no_done", 32'(dones - d0), 32'd0);
        check("midreset_sb_empty", 32'(sb.size()), 32'd0);

`ifdef REGDUMP_CHECKSUM_EN
        // Checksum of a sparse register file
        begin
            exp_t e;
            for (int i = 0; i < N; i++) rf[i] = '0;
            rf[5] = 32'hA5A5_A5A5;
            rf[6] = 32'h0000_FFFF;
            d0 = dones;
            push_range(0, N);
            e.adr  = '0;
            e.data = 32'hA5A5_5A5A;
            e.last = 1'b1;
            sb.push_back(e);
            pulse_start();
            wait_done(n);
            tick();
            check("csum_dones", 32'(dones - d0), 32'd1);
            check("csum_sb_empty", 32'(sb.size()), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
